rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: the in-order ALU/execute pipeline (port A) and the multi-cycle load unit (port M).
- Keeps a load scoreboard (one busy bit per architectural register) so issue logic can stall on RAW hazards against outstanding loads.
- Sits between the execute/memory stages and the register file's we/wa/wd inputs. It drives that write port from a registered output stage.

Parameters:
- STARVE_LIMIT, 3: consecutive cycles port M may be refused while valid before it is forced to win arbitration (legal range 1..15).
- CNT_W, 4: width of the starvation counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- a_valid  in  1  ALU writeback request
- a_ready  out  1  ALU request granted this cycle
- a_rd  in  5  ALU destination register
- a_data  in  32  ALU result
- m_valid  in  1  load writeback request
- m_ready  out  1  load request granted this cycle
- m_rd  in  5  load destination register
- m_data  in  32  load data
- iss_valid  in  1  load issued this cycle
- iss_rd  in  5  destination of the issued load
- q_rs1, q_rs2  in  5 each  source registers queried by decode
- q_busy1, q_busy2  out  1 each  source not yet readable from the register file
- rf_we  out  1  register-file write enable
- rf_wa  out  5  register-file write address
- rf_wd  out  32  register-file write data

Behaviour:
- Reset: rf_we=0, rf_wa=0, rf_wd=0, all busy bits cleared, starvation counter=0. Reset mid-operation discards any pending output write and all scoreboard state.
- Arbitration is combinational in the current cycle:
  - Only one port valid: that port is granted.
  - Both valid: A is granted unless starve_cnt==STARVE_LIMIT, in which case M is granted.
  - Neither valid: no grant.
- a_ready=grant_a and m_ready=grant_m, never both 1. A port holds valid and payload stable until it is granted.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when m_valid=1 and M is not granted.
  - Cleared when M is granted or m_valid=0.
- Output stage latency is one cycle. On the cycle after a grant: rf_we=1 and rf_wa/rf_wd hold the granted rd/data. With no grant, rf_we=0 and rf_wa/rf_wd hold their previous values.
- x0: a granted request with rd=0 completes its handshake, but rf_we stays 0 the next cycle.
- Scoreboard busy[31:1]:
  - Set when iss_valid=1 and iss_rd!=0.
  - Cleared when M is granted with m_rd matching.
  - Simultaneous set and clear of the same register: set wins, because a new load supersedes the completing one.
  - An iss_rd of 0 is ignored.
  - Port A grants never modify the scoreboard. WAW ordering against outstanding loads is the issue logic's responsibility.
- q_busyN = busy[q_rsN] | (rf_we & rf_wa==q_rsN & q_rsN!=0). The second term covers the cycle in which the write is still on the port. q_rsN=0 always returns 0.
- Port M writing a register whose busy bit is clear is legal and is written normally.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- When defined, four extra outputs exist:
  - q_fwd1, q_fwd2 (1 bit each)
  - q_data1, q_data2 (32 bits each)
- q_fwdN=1 when rf_we=1, rf_wa==q_rsN and q_rsN!=0. In that case q_dataN=rf_wd, and the output-stage term is removed from q_busyN, which then reflects busy[q_rsN] only.
- q_dataN=0 when q_fwdN=0.
- When the macro is undefined, these ports do not exist and q_busyN is exactly as in Behaviour.

Test Plan:
- Reset then idle: rst high 2 cycles with random inputs -> rf_we=0, rf_wa=0, rf_wd=0, q_busy1=q_busy2=0; after release, a single a_valid (rd=5, data=0xDEADBEEF) -> a_ready=1 same cycle, next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF.
- Contention/starvation with STARVE_LIMIT=3: a_valid and m_valid held high (m_rd=7, m_data=0x11) -> A granted cycles 0-2, M granted cycle 3, counter back to 0, rf_wa=7/rf_wd=0x11 in cycle 4.
- Scoreboard: iss_valid with iss_rd=9, query q_rs1=9 -> q_busy1=1 until M is granted with rd=9; q_busy1 stays 1 for one further cycle (output stage), then 0.
- Set/clear collision: busy[4]=1, M granted rd=4 in the same cycle as iss_valid rd=4 -> busy[4] remains 1.
- x0 handling: a_valid rd=0 data=0xFFFFFFFF -> a_ready=1, rf_we=0 next cycle; iss_valid iss_rd=0 -> q_busy for rs=0 stays 0.
- Reset mid-operation: busy[3]=1 and a grant pending, rst asserted -> next cycle rf_we=0, q_busy for rs=3 is 0, counter=0. With RF_WB_BYPASS_EN: write rd=6 data=0x55 on the port -> q_fwd1=1, q_data1=0x55, q_busy1=0 for q_rs1=6.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter (ALU port A vs. load port M) with a load scoreboard.
// Optional macro RF_WB_BYPASS_EN adds q_fwdN/q_dataN forwarding from the output stage.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [4:0]  m_rd,
  input  logic [31:0] m_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  output logic        q_busy1,
  output logic        q_busy2,
`ifdef RF_WB_BYPASS_EN
  output logic        q_fwd1,
  output logic        q_fwd2,
  output logic [31:0] q_data1,
  output logic [31:0] q_data2,
`endif
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic             grant_a_s;
  logic             grant_m_s;
  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic [31:0]      busy_q;
  logic [31:0]      busy_d;
  logic             rf_we_q;
  logic             rf_we_d;
  logic [4:0]       rf_wa_q;
  logic [4:0]       rf_wa_d;
  logic [31:0]      rf_wd_q;
  logic [31:0]      rf_wd_d;
  logic             os_hit1_s;
  logic             os_hit2_s;

  // A wins contention unless M has been refused STARVE_LIMIT cycles in a row.
  always_comb begin
    grant_a_s = 1'b0;
    grant_m_s = 1'b0;
    if (m_valid && (!a_valid || (starve_cnt_q == LIMIT_C))) begin
      grant_m_s = 1'b1;
    end else if (a_valid) begin
      grant_a_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
    end
  end

  assign a_ready = grant_a_s;
  assign m_ready = grant_m_s;

  // Next-state for starvation counter, scoreboard and output stage.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    busy_d       = busy_q;
    rf_we_d      = 1'b0;
    rf_wa_d      = rf_wa_q;
    rf_wd_d      = rf_wd_q;

    if (!m_valid || grant_m_s) begin
      starve_cnt_d = {CNT_W{1'b0}};
    end else if (starve_cnt_q < LIMIT_C) begin
      starve_cnt_d = starve_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt_d = starve_cnt_q;
    end

    if (grant_a_s) begin
      rf_we_d = (a_rd != 5'd0);
      rf_wa_d = a_rd;
      rf_wd_d = a_data;
    end else if (grant_m_s) begin
      rf_we_d = (m_rd != 5'd0);
      rf_wa_d = m_rd;
      rf_wd_d = m_data;
    end else begin
      rf_we_d = 1'b0;
    end

    // Set is applied after clear so a newly issued load supersedes a completing one.
    if (grant_m_s) begin
      busy_d[m_rd] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      busy_d[iss_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= {CNT_W{1'b0}};
      busy_q       <= 32'd0;
      rf_we_q      <= 1'b0;
      rf_wa_q      <= 5'd0;
      rf_wd_q      <= 32'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      busy_q       <= busy_d;
      rf_we_q      <= rf_we_d;
      rf_wa_q      <= rf_wa_d;
      rf_wd_q      <= rf_wd_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;

  assign os_hit1_s = rf_we_q && (rf_wa_q == q_rs1) && (q_rs1 != 5'd0);
  assign os_hit2_s = rf_we_q && (rf_wa_q == q_rs2) && (q_rs2 != 5'd0);

`ifdef RF_WB_BYPASS_EN
  // Output-stage value is forwarded, so it no longer counts as busy.
  always_comb begin
    q_busy1 = busy_q[q_rs1] && (q_rs1 != 5'd0);
    q_busy2 = busy_q[q_rs2] && (q_rs2 != 5'd0);
    q_fwd1  = os_hit1_s;
    q_fwd2  = os_hit2_s;
    q_data1 = os_hit1_s ? rf_wd_q : 32'd0;
    q_data2 = os_hit2_s ? rf_wd_q : 32'd0;
  end
`else
  // A write still sitting on the port is not yet readable from the register file.
  always_comb begin
    q_busy1 = (busy_q[q_rs1] && (q_rs1 != 5'd0)) || os_hit1_s;
    q_busy2 = (busy_q[q_rs2] && (q_rs2 != 5'd0)) || os_hit2_s;
  end
`endif

endmodule
